// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
// Memory-access pipeline stage. Converts EX/MEM load/store requests into a
// valid/ready data-memory transaction, steers store bytes onto the 32-bit
// bus, and extracts/extends load data. Stalls upstream until the access
// completes and emits bubbles (mem_reg_write=0) into the enable-less MEM/WB
// register while stalled.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   ex_mem_*             instruction currently in MEM (from EX/MEM register)
//   mem_*                MEM/WB inputs, stall and one-cycle fault flag
//   dmem_req_*           request channel (valid/ready), word address + byte enables
//   dmem_rsp_*           read response (valid only, no backpressure)
//
// Parameters
//   RSP_TIMEOUT          max cycles spent in WAIT before aborting with a fault;
//                        0 disables the timeout
//   CNT_W                timeout counter width (RSP_TIMEOUT < 2**CNT_W)
module mem_stage_lsu #(
    parameter int RSP_TIMEOUT = 0,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] ex_mem_pc_p4,
    input  logic [4:0]  ex_mem_rd,
    input  logic [31:0] ex_mem_alu_result,
    input  logic [31:0] ex_mem_rs2_data,
    input  logic        ex_mem_mem_read,
    input  logic        ex_mem_mem_write,
    input  logic [2:0]  ex_mem_funct3,
    input  logic        ex_mem_reg_write,
    input  logic [1:0]  ex_mem_reg_write_src,
    output logic [31:0] mem_pc_p4,
    output logic [4:0]  mem_rd,
    output logic [31:0] mem_alu_result,
    output logic [31:0] mem_mem_read_data,
    output logic        mem_reg_write,
    output logic [1:0]  mem_reg_write_src,
    output logic        mem_stall,
    output logic        mem_fault,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_req_we,
    output logic [31:0] dmem_req_addr,
    output logic [31:0] dmem_req_wdata,
    output logic [3:0]  dmem_req_be,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rsp_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [2:0]  funct3;
        logic [1:0]  off;
    } req_t;

    // Timeout fires on the RSP_TIMEOUT-th WAIT cycle without a response.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(RSP_TIMEOUT - 1);

    state_t           state, state_nxt;
    req_t             req_q, req_d;
    logic [31:0]      rdata_q;
    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_q;

    logic             access, illegal, misaligned, fault_cond, tmo_hit;
    logic [1:0]       off;
    logic [7:0]       lane_b;
    logic [15:0]      lane_h;
    logic [31:0]      load_ext;

    assign mem_pc_p4         = ex_mem_pc_p4;
    assign mem_rd            = ex_mem_rd;
    assign mem_alu_result    = ex_mem_alu_result;
    assign mem_reg_write_src = ex_mem_reg_write_src;

    // ---------------- request decode ----------------
    assign access = ex_mem_mem_read | ex_mem_mem_write;
    assign off    = ex_mem_alu_result[1:0];

    // Stores only have signed encodings; unsigned sizes are load-only.
    always_comb begin
        illegal = 1'b1;
        case (ex_mem_funct3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = ex_mem_mem_write;
            default:                illegal = 1'b1;
        endcase
    end

    assign misaligned = ((ex_mem_funct3[1:0] == 2'b01) && off[0]) ||
                        ((ex_mem_funct3[1:0] == 2'b10) && (off != 2'b00));
    assign fault_cond = access & (illegal | misaligned |
                                  (ex_mem_mem_read & ex_mem_mem_write));

    // Store steering: replicate the datum across the word so any lane the
    // byte enables pick holds the right bytes.
    always_comb begin
        req_d.we     = ex_mem_mem_write;
        req_d.addr   = {ex_mem_alu_result[31:2], 2'b00};
        req_d.funct3 = ex_mem_funct3;
        req_d.off    = off;
        case (ex_mem_funct3[1:0])
            2'b00: begin
                req_d.wdata = {4{ex_mem_rs2_data[7:0]}};
                req_d.be    = 4'b0001 << off;
            end
            2'b01: begin
                req_d.wdata = {2{ex_mem_rs2_data[15:0]}};
                req_d.be    = 4'b0011 << off;
            end
            default: begin
                req_d.wdata = ex_mem_rs2_data;
                req_d.be    = 4'b1111;
            end
        endcase
    end

    // ---------------- load extraction ----------------
    always_comb begin
        case (req_q.off)
            2'd0:    lane_b = dmem_rsp_rdata[7:0];
            2'd1:    lane_b = dmem_rsp_rdata[15:8];
            2'd2:    lane_b = dmem_rsp_rdata[23:16];
            default: lane_b = dmem_rsp_rdata[31:24];
        endcase
    end

    assign lane_h = req_q.off[1] ? dmem_rsp_rdata[31:16] : dmem_rsp_rdata[15:0];

    always_comb begin
        case (req_q.funct3)
            3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_ext = {24'd0, lane_b};
            3'b101:  load_ext = {16'd0, lane_h};
            default: load_ext = dmem_rsp_rdata;
        endcase
    end

    assign tmo_hit = (RSP_TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

    // ---------------- FSM: next state / outputs ----------------
    always_comb begin
        state_nxt         = state;
        dmem_req_valid    = 1'b0;
        dmem_req_we       = req_q.we;
        dmem_req_addr     = req_q.addr;
        dmem_req_wdata    = req_q.wdata;
        dmem_req_be       = req_q.be;
        mem_stall         = 1'b0;
        mem_fault         = 1'b0;
        mem_reg_write     = ex_mem_reg_write;
        mem_mem_read_data = '0;

        case (state)
            IDLE: begin
                if (fault_cond) begin
                    mem_fault     = 1'b1;
                    mem_reg_write = 1'b0;
                end else if (access) begin
                    // First cycle presents the request straight from EX/MEM
                    // so a ready memory accepts it without an extra cycle.
                    dmem_req_valid = 1'b1;
                    dmem_req_we    = req_d.we;
                    dmem_req_addr  = req_d.addr;
                    dmem_req_wdata = req_d.wdata;
                    dmem_req_be    = req_d.be;
                    mem_stall      = 1'b1;
                    mem_reg_write  = 1'b0;
                    if (dmem_req_ready)
                        state_nxt = req_d.we ? DONE : WAIT;
                    else
                        state_nxt = REQ;
                end
            end
            REQ: begin
                dmem_req_valid = 1'b1;
                mem_stall      = 1'b1;
                mem_reg_write  = 1'b0;
                if (dmem_req_ready)
                    state_nxt = req_q.we ? DONE : WAIT;
            end
            WAIT: begin
                mem_stall     = 1'b1;
                mem_reg_write = 1'b0;
                if (dmem_rsp_valid || tmo_hit)
                    state_nxt = DONE;
            end
            DONE: begin
                mem_mem_read_data = rdata_q;
                if (tmo_q) begin
                    mem_fault     = 1'b1;
                    mem_reg_write = 1'b0;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // State is already IDLE under reset, but the combinational IDLE
        // request path must also be silenced while rstn is low.
        if (!rstn) begin
            dmem_req_valid    = 1'b0;
            mem_stall         = 1'b0;
            mem_fault         = 1'b0;
            mem_reg_write     = ex_mem_reg_write;
            mem_mem_read_data = '0;
        end
    end

    // ---------------- state and captured request ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            req_q   <= '0;
            rdata_q <= '0;
            tmo_cnt <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (access && !fault_cond) begin
                        req_q   <= req_d;
                        rdata_q <= '0;  // stores and aborted loads report 0
                        tmo_cnt <= '0;
                        tmo_q   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (dmem_rsp_valid)
                        rdata_q <= load_ext;
                    else if (tmo_hit)
                        tmo_q <= 1'b1;
                    else
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    logic        clk;
    logic        rstn;
    logic [31:0] ex_mem_pc_p4;
    logic [4:0]  ex_mem_rd;
    logic [31:0] ex_mem_alu_result;
    logic [31:0] ex_mem_rs2_data;
    logic        ex_mem_mem_read;
    logic        ex_mem_mem_write;
    logic [2:0]  ex_mem_funct3;
    logic        ex_mem_reg_write;
    logic [1:0]  ex_mem_reg_write_src;
    logic [31:0] mem_pc_p4;
    logic [4:0]  mem_rd;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_mem_read_data;
    logic        mem_reg_write;
    logic [1:0]  mem_reg_write_src;
    logic        mem_stall;
    logic        mem_fault;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_req_we;
    logic [31:0] dmem_req_addr;
    logic [31:0] dmem_req_wdata;
    logic [3:0]  dmem_req_be;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_rdata;

    int checks   = 0;
    int failures = 0;

    mem_stage_lsu #(.RSP_TIMEOUT(4), .CNT_W(8)) dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .ex_mem_pc_p4         (ex_mem_pc_p4),
        .ex_mem_rd            (ex_mem_rd),
        .ex_mem_alu_result    (ex_mem_alu_result),
        .ex_mem_rs2_data      (ex_mem_rs2_data),
        .ex_mem_mem_read      (ex_mem_mem_read),
        .ex_mem_mem_write     (ex_mem_mem_write),
        .ex_mem_funct3        (ex_mem_funct3),
        .ex_mem_reg_write     (ex_mem_reg_write),
        .ex_mem_reg_write_src (ex_mem_reg_write_src),
        .mem_pc_p4            (mem_pc_p4),
        .mem_rd               (mem_rd),
        .mem_alu_result       (mem_alu_result),
        .mem_mem_read_data    (mem_mem_read_data),
        .mem_reg_write        (mem_reg_write),
        .mem_reg_write_src    (mem_reg_write_src),
        .mem_stall            (mem_stall),
        .mem_fault            (mem_fault),
        .dmem_req_valid       (dmem_req_valid),
        .dmem_req_ready       (dmem_req_ready),
        .dmem_req_we          (dmem_req_we),
        .dmem_req_addr        (dmem_req_addr),
        .dmem_req_wdata       (dmem_req_wdata),
        .dmem_req_be          (dmem_req_be),
        .dmem_rsp_valid       (dmem_rsp_valid),
        .dmem_rsp_rdata       (dmem_rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit lsu_fault(input logic rd, input logic wr,
                                     input logic [2:0] f3, input logic [31:0] addr);
        bit legal;
        if (rd && wr) return 1'b1;
        if (wr) legal = f3 inside {3'b000, 3'b001, 3'b010};
        else    legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        if (!legal) return 1'b1;
        return (addr % nbytes(f3)) != 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] addr);
        logic [3:0] be;
        int o, n;
        o = int'(addr % 4);
        n = nbytes(f3);
        for (int i = 0; i < 4; i++) be[i] = (i >= o) && (i < o + n);
        return be;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] data);
        logic [31:0] w;
        int n;
        n = nbytes(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = data[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        logic [31:0] v;
        int o, n;
        o = int'(addr % 4);
        n = nbytes(f3);
        v = '0;
        for (int k = 0; k < n; k++) v = v | (32'(rdata[8*(o+k) +: 8]) << (8*k));
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
        return v;
    endfunction

    task automatic chk(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
        end
    endtask

    // Presents one instruction in EX/MEM at the current negedge, plays the
    // memory side (ready after rdly cycles, response dly cycles after accept,
    // dly=0 meaning never), checks every cycle, and returns at the negedge
    // where the next instruction would enter.
    task automatic do_access(input string tag, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] data, input logic regw,
                             input int rdly, input int dly, input logic [31:0] rdata);
        logic [31:0] pc;
        logic [4:0]  rdst;
        logic [1:0]  src;
        int          k;
        pc   = $urandom;
        rdst = 5'($urandom);
        src  = 2'($urandom);
        ex_mem_pc_p4         = pc;
        ex_mem_rd            = rdst;
        ex_mem_alu_result    = addr;
        ex_mem_rs2_data      = data;
        ex_mem_mem_read      = rd;
        ex_mem_mem_write     = wr;
        ex_mem_funct3        = f3;
        ex_mem_reg_write     = regw;
        ex_mem_reg_write_src = src;
        dmem_req_ready       = (rdly == 0);
        dmem_rsp_valid       = 1'b0;
        dmem_rsp_rdata       = $urandom;
        #2;
        chk(tag, "pc_pass",  mem_pc_p4, pc);
        chk(tag, "rd_pass",  32'(mem_rd), 32'(rdst));
        chk(tag, "alu_pass", mem_alu_result, addr);
        chk(tag, "src_pass", 32'(mem_reg_write_src), 32'(src));
        if (!(rd || wr)) begin
            chk(tag, "idle_valid", 32'(dmem_req_valid), 32'd0);
            chk(tag, "idle_stall", 32'(mem_stall), 32'd0);
            chk(tag, "idle_fault", 32'(mem_fault), 32'd0);
            chk(tag, "idle_regw",  32'(mem_reg_write), 32'(regw));
            chk(tag, "idle_rdata", mem_mem_read_data, 32'd0);
        end else if (lsu_fault(rd, wr, f3, addr)) begin
            chk(tag, "flt_valid", 32'(dmem_req_valid), 32'd0);
            chk(tag, "flt_fault", 32'(mem_fault), 32'd1);
            chk(tag, "flt_regw",  32'(mem_reg_write), 32'd0);
            chk(tag, "flt_stall", 32'(mem_stall), 32'd0);
        end else begin
            for (int c = 0; c <= rdly; c++) begin
                if (c > 0) begin
                    @(negedge clk);
                    dmem_req_ready = (c == rdly);
                    dmem_rsp_valid = 1'b0;
                    #2;
                end
                chk(tag, "req_valid", 32'(dmem_req_valid), 32'd1);
                chk(tag, "req_stall", 32'(mem_stall), 32'd1);
                chk(tag, "req_regw",  32'(mem_reg_write), 32'd0);
                chk(tag, "req_we",    32'(dmem_req_we), 32'(wr));
                chk(tag, "req_addr",  dmem_req_addr, {addr[31:2], 2'b00});
                if (wr || nbytes(f3) == 4) chk(tag, "req_be", 32'(dmem_req_be), 32'(exp_be(f3, addr)));
                if (wr) chk(tag, "req_wdata", dmem_req_wdata, exp_wdata(f3, data));
                if (c == rdly) begin
                    // A response in the accept cycle must be ignored.
                    dmem_rsp_valid = 1'b1;
                    dmem_rsp_rdata = ~rdata;
                end
            end
            if (rd && dly == 0) begin
                k = 0;
                do begin
                    @(negedge clk);
                    dmem_req_ready = 1'b0;
                    dmem_rsp_valid = 1'b0;
                    #2;
                    k++;
                    if (mem_stall === 1'b1) chk(tag, "wait_valid", 32'(dmem_req_valid), 32'd0);
                end while (mem_stall === 1'b1 && k < 10);
                chk(tag, "tmo_latency", 32'(k == 5 || k == 6), 32'd1);
                chk(tag, "tmo_fault", 32'(mem_fault), 32'd1);
                chk(tag, "tmo_regw",  32'(mem_reg_write), 32'd0);
                chk(tag, "tmo_rdata", mem_mem_read_data, 32'd0);
            end else begin
                if (rd) begin
                    for (int w = 1; w <= dly; w++) begin
                        @(negedge clk);
                        dmem_req_ready = 1'b0;
                        dmem_rsp_valid = (w == dly);
                        dmem_rsp_rdata = (w == dly) ? rdata : $urandom;
                        #2;
                        chk(tag, "wait_stall", 32'(mem_stall), 32'd1);
                        chk(tag, "wait_valid", 32'(dmem_req_valid), 32'd0);
                        chk(tag, "wait_regw",  32'(mem_reg_write), 32'd0);
                    end
                end
                @(negedge clk);
                dmem_req_ready = 1'b0;
                dmem_rsp_valid = 1'b0;
                #2;
                chk(tag, "done_stall", 32'(mem_stall), 32'd0);
                chk(tag, "done_valid", 32'(dmem_req_valid), 32'd0);
                chk(tag, "done_fault", 32'(mem_fault), 32'd0);
                chk(tag, "done_regw",  32'(mem_reg_write), 32'(regw));
                chk(tag, "done_rdata", mem_mem_read_data, rd ? exp_load(f3, addr, rdata) : 32'd0);
            end
        end
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic        r_rd, r_wr, r_regw;
        logic [2:0]  r_f3;
        logic [31:0] r_addr;
        int          sel;

        // Reset with a load sitting in EX/MEM.
        rstn                 = 1'b0;
        ex_mem_pc_p4         = 32'h0000_1004;
        ex_mem_rd            = 5'd3;
        ex_mem_alu_result    = 32'h0000_0100;
        ex_mem_rs2_data      = 32'd0;
        ex_mem_mem_read      = 1'b1;
        ex_mem_mem_write     = 1'b0;
        ex_mem_funct3        = 3'b010;
        ex_mem_reg_write     = 1'b1;
        ex_mem_reg_write_src = 2'd1;
        dmem_req_ready       = 1'b1;
        dmem_rsp_valid       = 1'b0;
        dmem_rsp_rdata       = 32'd0;
        #2;
        chk("reset", "valid", 32'(dmem_req_valid), 32'd0);
        chk("reset", "stall", 32'(mem_stall), 32'd0);
        chk("reset", "fault", 32'(mem_fault), 32'd0);
        chk("reset", "rdata", mem_mem_read_data, 32'd0);
        chk("reset", "regw",  32'(mem_reg_write), 32'd1);
        chk("reset", "pc",    mem_pc_p4, 32'h0000_1004);
        @(negedge clk);
        rstn = 1'b1;

        // Directed cases.
        do_access("lw",  1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0, 1'b1, 0, 1, 32'hDEAD_BEEF);
        do_access("lb",  1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 1'b1, 0, 1, 32'h80FF_1234);
        do_access("lbu", 1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'd0, 1'b1, 0, 1, 32'h80FF_1234);
        do_access("lhu", 1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'd0, 1'b1, 0, 2, 32'h80FF_1234);
        do_access("sh",  1'b0, 1'b1, 3'b001, 32'h0000_0206, 32'h0000_ABCD, 1'b0, 3, 0, 32'd0);
        do_access("lw_mis", 1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'd0, 1'b1, 0, 1, 32'd0);
        do_access("after_flt", 1'b0, 1'b0, 3'b000, 32'h0000_0040, 32'd0, 1'b1, 0, 0, 32'd0);
        do_access("sb_bu", 1'b0, 1'b1, 3'b100, 32'h0000_0300, 32'h11, 1'b0, 0, 0, 32'd0);
        do_access("rdwr", 1'b1, 1'b1, 3'b010, 32'h0000_0300, 32'h11, 1'b1, 0, 1, 32'd0);

        // Response timeout, then a late response that must be dropped.
        do_access("tmo", 1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'd0, 1'b1, 0, 0, 32'd0);
        ex_mem_mem_read  = 1'b0;
        ex_mem_mem_write = 1'b0;
        ex_mem_reg_write = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            dmem_rsp_valid = (i == 2);
            dmem_rsp_rdata = 32'hFFFF_FFFF;
            #2;
            chk("tmo_late", "fault", 32'(mem_fault), 32'd0);
            chk("tmo_late", "rdata", mem_mem_read_data, 32'd0);
            chk("tmo_late", "stall", 32'(mem_stall), 32'd0);
            chk("tmo_late", "regw",  32'(mem_reg_write), 32'd1);
            @(negedge clk);
        end
        dmem_rsp_valid = 1'b0;

        // Reset dropped while the request is held in REQ.
        ex_mem_alu_result = 32'h0000_0300;
        ex_mem_mem_read   = 1'b1;
        ex_mem_funct3     = 3'b010;
        dmem_req_ready    = 1'b0;
        #2;
        chk("rst_req", "valid_idle", 32'(dmem_req_valid), 32'd1);
        @(negedge clk);
        #2;
        chk("rst_req", "valid_req", 32'(dmem_req_valid), 32'd1);
        #1 rstn = 1'b0;
        #1;
        chk("rst_req", "valid", 32'(dmem_req_valid), 32'd0);
        chk("rst_req", "stall", 32'(mem_stall), 32'd0);
        chk("rst_req", "fault", 32'(mem_fault), 32'd0);
        chk("rst_req", "regw",  32'(mem_reg_write), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        do_access("rst_reissue", 1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'd0, 1'b1, 1, 1, 32'h1234_5678);

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            sel    = $urandom_range(0, 9);
            r_rd   = (sel <= 3) || (sel == 9);
            r_wr   = (sel >= 4 && sel <= 7) || (sel == 9);
            r_f3   = 3'($urandom_range(0, 7));
            r_addr = $urandom;
            if ($urandom_range(0, 3) != 0) r_addr = r_addr - (r_addr % nbytes(r_f3));
            r_regw = 1'($urandom);
            do_access("rand", r_rd, r_wr, r_f3, r_addr, $urandom, r_regw,
                      $urandom_range(0, 3), $urandom_range(1, 3), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Memory-access stage between the EX/MEM and MEM/WB pipeline registers. It turns load/store requests from EX/MEM into a valid/ready data-memory transaction and applies store byte-lane steering and load extraction with sign or zero extension. It stalls upstream until the access completes. Its mem_* outputs feed the MEM/WB register directly; that register has no enable, so this block emits bubbles (mem_reg_write=0) while stalled.

Parameters:
RSP_TIMEOUT, 0, max cycles in WAIT before abort with fault; 0 disables the timeout counter
CNT_W, 8, width of timeout counter; RSP_TIMEOUT must be < 2**CNT_W

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
ex_mem_pc_p4  in  32  PC+4 of instruction in MEM
ex_mem_rd  in  5  destination register
ex_mem_alu_result  in  32  ALU result / effective address
ex_mem_rs2_data  in  32  store data
ex_mem_mem_read  in  1  load instruction
ex_mem_mem_write  in  1  store instruction
ex_mem_funct3  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
ex_mem_reg_write  in  1  writeback enable
ex_mem_reg_write_src  in  2  writeback mux select
mem_pc_p4  out  32  passthrough to MEM/WB
mem_rd  out  5  passthrough
mem_alu_result  out  32  passthrough
mem_mem_read_data  out  32  extended load data
mem_reg_write  out  1  gated writeback enable
mem_reg_write_src  out  2  passthrough
mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
mem_fault  out  1  one-cycle misaligned/illegal/timeout flag
dmem_req_valid  out  1  request valid
dmem_req_ready  in  1  memory accepts request
dmem_req_we  out  1  1=store
dmem_req_addr  out  32  word address {addr[31:2],2'b00}
dmem_req_wdata  out  32  lane-steered store data
dmem_req_be  out  4  byte enables
dmem_rsp_valid  in  1  read data valid
dmem_rsp_rdata  in  32  read word

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE. Reset (async, rstn=0) forces IDLE, clears the captured request registers, load-data register and timeout counter, and deasserts dmem_req_valid immediately.
- access = mem_read|mem_write.
- fault_cond = misaligned (H with addr[0]=1, W with addr[1:0]!=0), or illegal funct3 (011/110/111; for stores, any funct3 other than 000/001/010), or mem_read&mem_write both set.
- IDLE, no access: no bus activity; mem_stall=0; outputs pass through; mem_reg_write=ex_mem_reg_write.
- IDLE, fault_cond: no bus request; mem_fault=1 this cycle; mem_reg_write=0; mem_stall=0.
- IDLE, valid access:
  - dmem_req_* are driven combinationally from the inputs; the request is also captured into registers.
  - mem_stall=1, mem_reg_write=0.
  - If ready: store -> DONE; load -> WAIT. Otherwise -> REQ.
- REQ: dmem_req_* are driven from the captured registers, held stable while valid=1 and ready=0; stall=1, reg_write=0. On ready: store -> DONE, load -> WAIT.
- WAIT:
  - stall=1, reg_write=0, valid=0.
  - A response is never expected in the accept cycle; dmem_rsp_valid there is ignored.
  - On rsp_valid: latch the extracted data -> DONE.
  - If RSP_TIMEOUT>0 and the counter reaches RSP_TIMEOUT: mem_fault=1, mem_reg_write=0 in the following DONE, and any late response is dropped.
- DONE:
  - stall=0 and mem_reg_write=ex_mem_reg_write (unless timed out); mem_mem_read_data = latched register.
  - The current EX/MEM contents are the completed instruction and are not re-issued. Next state is IDLE.
- Store steering:
  - SB: wdata = byte replicated x4, be = 0001<<addr[1:0].
  - SH: wdata = half replicated x2, be = 0011<<addr[1:0].
  - SW: be=1111.
- Load extract: select lane by addr[1:0]. B/H sign-extend bit 7/15; BU/HU zero-extend; W passes the word.
- mem_mem_read_data is 0 outside DONE.
- Latency:
  - Load with ready=1 and rsp on the next cycle: 3 cycles, 2 stall cycles.
  - Store with ready=1: 2 cycles, 1 stall cycle.
- Reset mid-transaction abandons it; rsp_valid arriving in IDLE is ignored.
- Output values with rstn=0: dmem_req_valid=0, mem_stall=0, mem_fault=0, mem_mem_read_data=0. Passthrough outputs follow the inputs; mem_reg_write follows ex_mem_reg_write.

Test Plan:
- LW addr 0x100, ready=1, rsp next cycle rdata=0xDEADBEEF -> req addr 0x100, be=1111, we=0; stall 1,1,0; DONE cycle read_data=0xDEADBEEF, reg_write=1.
- LB addr 0x103, rdata=0x80FF_1234 -> read_data=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU addr 0x102 -> 0x000080FF.
- SH addr 0x206 data 0x0000ABCD, ready low 3 cycles -> valid held 4 cycles; addr 0x204, be=1100, wdata=0xABCDABCD stable throughout; stall deasserts in DONE.
- LW addr 0x101 -> no dmem_req_valid; mem_fault=1 for one cycle; mem_reg_write=0; stall=0.
- RSP_TIMEOUT=4, load accepted, no response -> fault pulses and reg_write=0 in DONE; a rsp_valid 2 cycles later is ignored and read_data stays 0.
- rstn dropped during REQ -> dmem_req_valid=0 asynchronously; after release, state is IDLE and the next load issues normally.
